commit_store_arbiter: RTL and testbench

- Arbitrates the single data-memory port between speculative load requests from the load unit and committed stores released by the retire stage.
- On retire_store_valid, the block reads the store-queue entry named by retire_store_id and enqueues it in a committed-store FIFO. It then drains that FIFO to memory, interleaved with loads.
- A starvation counter and a store-to-load address-conflict check guarantee forward progress and memory ordering.
- Sits between the Retire stage, the store queue and the data-memory interface.

---
 rtl/commit_store_arbiter_pkg.sv | 31 +++
 rtl/commit_store_arbiter_if.sv | 26 ++
 rtl/commit_store_arbiter_fifo.sv | 70 +++++++
 rtl/commit_store_arbiter.sv | 130 +++++++++++++
 tb/tb_commit_store_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_store_arbiter_pkg.sv
// Shared types for the commit-store arbiter slice.
//   commit_store_t : one committed store (address, data, byte strobes)
//   arb_state_e    : memory-port FSM states
package commit_store_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned STRB_WIDTH       = DATA_WIDTH / 8;
  localparam int unsigned STORE_ID_WIDTH   = 4;
  localparam int unsigned LD_TAG_WIDTH     = 6;
  localparam int unsigned DEF_FIFO_DEPTH   = 8;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } commit_store_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    LD_WAIT = 2'd2
  } arb_state_e;

  // Word address used for the store-to-load conflict check.
  function automatic logic [ADDR_WIDTH-3:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/commit_store_arbiter_if.sv
// Data-memory port bundle.
//   master : arbiter side (drives mem_req_*, receives ready/response)
//   slave  : memory side
interface commit_store_arbiter_if;
  import commit_store_arbiter_pkg::*;

  logic                  mem_req_valid;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [STRB_WIDTH-1:0] mem_req_wstrb;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/commit_store_arbiter_fifo.sv
// Committed-store FIFO with a parallel word-address match over valid entries.
//   push_i/push_entry_i : enqueue (dropped when full)
//   pop_i               : dequeue head (ignored when empty)
//   match_word_i        : word address compared against every valid entry
//   head_o, full_o, empty_o, match_o
module commit_store_fifo
  import commit_store_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  commit_store_t         push_entry_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-3:0] match_word_i,
  output commit_store_t         head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  match_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  commit_store_t    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  // Payload needs no reset; valid_q qualifies every use of it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    match_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (word_of(mem_q[i].addr) == match_word_i)) match_o = 1'b1;
    end
  end

endmodule

// File: rtl/commit_store_arbiter.sv
// Arbitrates the data-memory port between speculative loads and committed
// stores drained from a FIFO filled by the retire stage.
//   retire_store_* / sq_rd_* : store commit and store-queue read
//   ld_req_* / ld_resp_*     : load unit request/response
//   mem                      : data-memory port (one outstanding transaction)
//   store_fifo_full, stores_drained : status
module commit_store_arbiter
  import commit_store_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      retire_store_valid,
  input  logic [STORE_ID_WIDTH-1:0] retire_store_id,
  output logic [STORE_ID_WIDTH-1:0] sq_rd_id,
  input  logic [ADDR_WIDTH-1:0]     sq_rd_addr,
  input  logic [DATA_WIDTH-1:0]     sq_rd_data,
  input  logic [STRB_WIDTH-1:0]     sq_rd_strb,
  output logic                      store_fifo_full,
  output logic                      stores_drained,
  input  logic                      ld_req_valid,
  input  logic [ADDR_WIDTH-1:0]     ld_req_addr,
  input  logic [LD_TAG_WIDTH-1:0]   ld_req_tag,
  output logic                      ld_req_ready,
  output logic                      ld_resp_valid,
  output logic [DATA_WIDTH-1:0]     ld_resp_data,
  output logic [LD_TAG_WIDTH-1:0]   ld_resp_tag,
  commit_store_arbiter_if.master    mem
);

  localparam int unsigned          SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]      LIMIT_C = SC_W'(STARVE_LIMIT);

  arb_state_e              state_q, state_d;
  logic [SC_W-1:0]         starve_q, starve_d;
  logic [LD_TAG_WIDTH-1:0] tag_q, tag_d;
  logic                    killed_q, killed_d;

  commit_store_t head;
  logic          fifo_full, fifo_empty, conflict;
  logic          grant_st, grant_ld, fire, resp_ld;

  commit_store_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (retire_store_valid),
    .push_entry_i ('{addr: sq_rd_addr, data: sq_rd_data, strb: sq_rd_strb}),
    .pop_i        (fire && grant_st),
    .match_word_i (word_of(ld_req_addr)),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .match_o      (conflict)
  );

  assign sq_rd_id        = retire_store_id;
  assign store_fifo_full = fifo_full;
  assign stores_drained  = fifo_empty && (state_q != ST_WAIT);

  always_comb begin
    grant_st = 1'b0;
    grant_ld = 1'b0;
    if (state_q == IDLE) begin
      if (!fifo_empty && (!ld_req_valid || fifo_full || starve_q == LIMIT_C || conflict))
        grant_st = 1'b1;
      else if (ld_req_valid && !flush)
        grant_ld = 1'b1;
    end
  end

  assign fire              = (grant_st || grant_ld) && mem.mem_req_ready;
  assign ld_req_ready      = grant_ld && mem.mem_req_ready;
  assign mem.mem_req_valid = grant_st || grant_ld;
  assign mem.mem_req_we    = grant_st;
  assign mem.mem_req_addr  = grant_st ? head.addr : (grant_ld ? ld_req_addr : '0);
  assign mem.mem_req_wdata = grant_st ? head.data : '0;
  assign mem.mem_req_wstrb = grant_st ? head.strb : '0;

  // A flush coinciding with the response also kills it.
  assign resp_ld       = (state_q == LD_WAIT) && mem.mem_resp_valid;
  assign ld_resp_valid = resp_ld && !killed_q && !flush;
  assign ld_resp_data  = resp_ld ? mem.mem_resp_rdata : '0;
  assign ld_resp_tag   = tag_q;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    killed_d = killed_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (grant_st) begin
            state_d = ST_WAIT;
          end else begin
            state_d  = LD_WAIT;
            tag_d    = ld_req_tag;
            killed_d = 1'b0;
          end
        end
      end
      ST_WAIT: if (mem.mem_resp_valid) state_d = IDLE;
      LD_WAIT: begin
        if (flush) killed_d = 1'b1;
        if (mem.mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((fire && grant_st) || fifo_empty) starve_d = '0;
    else if (fire && grant_ld && starve_q != LIMIT_C) starve_d = starve_q + SC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tag_q    <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
      killed_q <= killed_d;
    end
  end

endmodule

// File: tb/tb_commit_store_arbiter.sv
module tb_commit_store_arbiter;
  import commit_store_arbiter_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic                      retire_store_valid;
  logic [STORE_ID_WIDTH-1:0] retire_store_id;
  logic [STORE_ID_WIDTH-1:0] sq_rd_id;
  logic [ADDR_WIDTH-1:0]     sq_rd_addr;
  logic [DATA_WIDTH-1:0]     sq_rd_data;
  logic [STRB_WIDTH-1:0]     sq_rd_strb;
  logic                      store_fifo_full;
  logic                      stores_drained;
  logic                      ld_req_valid;
  logic [ADDR_WIDTH-1:0]     ld_req_addr;
  logic [LD_TAG_WIDTH-1:0]   ld_req_tag;
  logic                      ld_req_ready;
  logic                      ld_resp_valid;
  logic [DATA_WIDTH-1:0]     ld_resp_data;
  logic [LD_TAG_WIDTH-1:0]   ld_resp_tag;

  commit_store_arbiter_if bus ();

  commit_store_arbiter #(.FIFO_DEPTH(8), .STARVE_LIMIT(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .retire_store_valid (retire_store_valid),
    .retire_store_id    (retire_store_id),
    .sq_rd_id           (sq_rd_id),
    .sq_rd_addr         (sq_rd_addr),
    .sq_rd_data         (sq_rd_data),
    .sq_rd_strb         (sq_rd_strb),
    .store_fifo_full    (store_fifo_full),
    .stores_drained     (stores_drained),
    .ld_req_valid       (ld_req_valid),
    .ld_req_addr        (ld_req_addr),
    .ld_req_tag         (ld_req_tag),
    .ld_req_ready       (ld_req_ready),
    .ld_resp_valid      (ld_resp_valid),
    .ld_resp_data       (ld_resp_data),
    .ld_resp_tag        (ld_resp_tag),
    .mem                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model and request log
  logic        log_we   [256];
  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  logic [3:0]  log_strb [256];
  int          n_req    = 0;
  int          n_ldresp = 0;
  logic [5:0]  last_tag;
  logic [31:0] last_data;
  int          resp_dly = 1;
  logic        pend     = 1'b0;
  int          cd       = 0;
  logic [31:0] pend_addr;
  logic        fire_s, ld_acc;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] a;
    #1;
    if (ld_resp_valid) begin
      n_ldresp++;
      last_tag  = ld_resp_tag;
      last_data = ld_resp_data;
    end
    fire_s = bus.mem_req_valid && bus.mem_req_ready;
    ld_acc = ld_req_valid && ld_req_ready;
    a      = bus.mem_req_addr;
    if (fire_s && n_req < 256) begin
      log_we[n_req]   = bus.mem_req_we;
      log_addr[n_req] = bus.mem_req_addr;
      log_data[n_req] = bus.mem_req_wdata;
      log_strb[n_req] = bus.mem_req_wstrb;
      n_req++;
    end
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    if (fire_s) begin
      pend      = 1'b1;
      cd        = resp_dly;
      pend_addr = a;
    end
    if (pend) begin
      cd--;
      if (cd == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = ~pend_addr;
        pend               = 1'b0;
      end
    end
  endtask

  task automatic retire(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    retire_store_valid = 1'b1;
    retire_store_id    = id;
    sq_rd_addr         = a;
    sq_rd_data         = d;
    sq_rd_strb         = s;
    tick();
    retire_store_valid = 1'b0;
  endtask

  task automatic wait_drained(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (stores_drained && !pend && !bus.mem_resp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_quiet(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!pend && !bus.mem_resp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic load_until_accepted(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (ld_acc) begin
        ok = 1'b1;
        break;
      end
    end
    ld_req_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst && retire_store_valid)
      assert (!store_fifo_full) else $error("FAIL retire_while_full");
  end

  initial begin
    logic        ok;
    int          base, r0;
    logic [14:0] we_pat;

    rst                = 1'b1;
    flush              = 1'b0;
    retire_store_valid = 1'b0;
    retire_store_id    = '0;
    sq_rd_addr         = '0;
    sq_rd_data         = '0;
    sq_rd_strb         = '0;
    ld_req_valid       = 1'b0;
    ld_req_addr        = '0;
    ld_req_tag         = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    tick();
    tick();
    check_eq("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    check_eq("rst_full", store_fifo_full, 1'b0);
    check_eq("rst_drained", stores_drained, 1'b1);
    check_eq("rst_ld_req_ready", ld_req_ready, 1'b0);
    check_eq("rst_ld_resp_valid", ld_resp_valid, 1'b0);
    rst = 1'b0;
    tick();

    // single store, response two cycles after request
    bus.mem_req_ready = 1'b1;
    resp_dly = 2;
    base = n_req;
    retire_store_id = 4'h9;
    #1;
    check_eq("t1_sq_rd_id", sq_rd_id, 4'h9);
    retire(4'h9, 32'h100, 32'hDEADBEEF, 4'hF);
    check_eq("t1_not_drained", stores_drained, 1'b0);
    wait_drained(30, ok);
    check_eq("t1_drain_wait", ok, 1'b1);
    check_eq("t1_nreq", n_req - base, 1);
    check_eq("t1_we", log_we[base], 1'b1);
    check_eq("t1_addr", log_addr[base], 32'h100);
    check_eq("t1_data", log_data[base], 32'hDEADBEEF);
    check_eq("t1_strb", log_strb[base], 4'hF);
    check_eq("t1_drained", stores_drained, 1'b1);

    // fill to full, then drain in order
    bus.mem_req_ready = 1'b0;
    resp_dly = 1;
    base = n_req;
    for (int i = 0; i < 8; i++)
      retire(4'(i), 32'h1000 + 32'(i) * 4, 32'h11110000 + 32'(i), 4'(i + 1));
    check_eq("t2_full", store_fifo_full, 1'b1);
    bus.mem_req_ready = 1'b1;
    tick();
    check_eq("t2_full_drop", store_fifo_full, 1'b0);
    wait_drained(60, ok);
    check_eq("t2_drain_wait", ok, 1'b1);
    check_eq("t2_nreq", n_req - base, 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t2_addr%0d", i), log_addr[base + i], 32'h1000 + 32'(i) * 4);
      check_eq($sformatf("t2_data%0d", i), log_data[base + i], 32'h11110000 + 32'(i));
    end

    // starvation: 4 loads then 1 store
    bus.mem_req_ready = 1'b0;
    retire(4'h0, 32'h300, 32'hA0, 4'hF);
    retire(4'h1, 32'h304, 32'hA1, 4'hF);
    retire(4'h2, 32'h308, 32'hA2, 4'hF);
    base = n_req;
    r0 = n_ldresp;
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'h200;
    ld_req_tag   = 6'h01;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 100 && n_req < base + 15; i++) tick();
    ld_req_valid = 1'b0;
    wait_drained(30, ok);
    check_eq("t3_drain_wait", ok, 1'b1);
    we_pat = '0;
    for (int i = 0; i < 15; i++) we_pat[i] = log_we[base + i];
    check_eq("t3_grant_pattern", we_pat, 15'h4210);
    check_eq("t3_ld_resps", n_ldresp - r0, 12);

    // conflicting load waits for store
    bus.mem_req_ready = 1'b0;
    retire(4'h3, 32'h104, 32'h0BADF00D, 4'h3);
    base = n_req;
    r0 = n_ldresp;
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'h104;
    ld_req_tag   = 6'h2A;
    bus.mem_req_ready = 1'b1;
    load_until_accepted(20, ok);
    check_eq("t4_ld_accept", ok, 1'b1);
    wait_drained(20, ok);
    tick();
    check_eq("t4_first_we", log_we[base], 1'b1);
    check_eq("t4_first_addr", log_addr[base], 32'h104);
    check_eq("t4_second_we", log_we[base + 1], 1'b0);
    check_eq("t4_resp_count", n_ldresp - r0, 1);
    check_eq("t4_resp_tag", last_tag, 6'h2A);
    check_eq("t4_resp_data", last_data, 32'hFFFFFEFB);

    // flush during LD_WAIT kills the response
    resp_dly = 3;
    r0 = n_ldresp;
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'h40;
    ld_req_tag   = 6'h15;
    load_until_accepted(10, ok);
    check_eq("t5_ld_accept", ok, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_quiet(20, ok);
    tick();
    check_eq("t5_killed", n_ldresp - r0, 0);
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'h44;
    ld_req_tag   = 6'h16;
    load_until_accepted(10, ok);
    check_eq("t5_next_accept", ok, 1'b1);
    wait_quiet(20, ok);
    tick();
    check_eq("t5_next_count", n_ldresp - r0, 1);
    check_eq("t5_next_tag", last_tag, 6'h16);
    check_eq("t5_next_data", last_data, 32'hFFFFFFBB);

    // reset during ST_WAIT with 3 queued
    bus.mem_req_ready = 1'b0;
    resp_dly = 4;
    for (int i = 0; i < 4; i++) retire(4'(i), 32'h600 + 32'(i) * 4, 32'hC0 + 32'(i), 4'hF);
    base = n_req;
    bus.mem_req_ready = 1'b1;
    tick();
    check_eq("t6_store_issued", n_req - base, 1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_req_valid", bus.mem_req_valid, 1'b0);
    check_eq("t6_rst_we", bus.mem_req_we, 1'b0);
    check_eq("t6_rst_addr", bus.mem_req_addr, 32'h0);
    check_eq("t6_rst_full", store_fifo_full, 1'b0);
    check_eq("t6_rst_drained", stores_drained, 1'b1);
    check_eq("t6_rst_ld_resp", ld_resp_valid, 1'b0);
    tick();
    rst = 1'b0;
    base = n_req;
    r0 = n_ldresp;
    for (int i = 0; i < 6; i++) tick();
    check_eq("t6_no_req_after", n_req - base, 0);
    check_eq("t6_no_ld_resp", n_ldresp - r0, 0);
    check_eq("t6_drained_after", stores_drained, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
